dmem_arbiter: RTL and testbench

Arbiter and sequencer for the single-port synchronous data memory of the 5-stage RISC-V pipeline. It shares the memory between the pipeline MEM stage (the core port) and a read-only debug/readout port that drives the board LED display from the `select` switches. The core port has priority. A bounded-wait counter guarantees the debug port a slot, and the core is stalled for that cycle. The block tracks the one-cycle read latency of the memory and routes returning data to the port that issued the read.

---
 rtl/dmem_arbiter.sv | 61 ++++++
 tb/tb_dmem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous data memory between the core MEM stage and a read-only debug port
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_stall,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_rvalid,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_valid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {R_NONE, R_CORE, R_DBG} ret_t;
  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);
  ret_t       ret_state;
  logic [3:0] wait_cnt;
  logic       debug_wins;
  logic       core_wins;
  // Grant decision and access routing; every output is forced low while reset is held
  always_comb begin
    debug_wins  = dbg_req & (~core_req | (wait_cnt == MAX_CNT));
    core_wins   = core_req & ~debug_wins;
    dbg_gnt     = ~reset & debug_wins;
    core_stall  = ~reset & core_req & debug_wins;
    mem_en      = ~reset & (debug_wins | core_wins);
    mem_we      = ~reset & core_wins & core_we;
    mem_addr    = reset ? '0 : debug_wins ? dbg_addr : core_wins ? core_addr : '0;
    mem_wdata   = (~reset & core_wins) ? core_wdata : '0;
    core_rvalid = ret_state == R_CORE;
    core_rdata  = core_rvalid ? mem_rdata : '0;
  end
  // Return-owner tracking, starvation counter and the registered debug readout
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ret_state <= R_NONE;
      wait_cnt  <= '0;
      dbg_rdata <= '0;
      dbg_valid <= 1'b0;
    end else begin
      ret_state <= debug_wins ? R_DBG : (core_wins & ~core_we) ? R_CORE : R_NONE;
      wait_cnt  <= (~dbg_req | debug_wins) ? 4'd0 :
                   (core_wins & (wait_cnt < MAX_CNT)) ? wait_cnt + 4'd1 : wait_cnt;
      dbg_valid <= ret_state == R_DBG;
      if (ret_state == R_DBG) dbg_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a one-cycle-latency memory model
module tb_dmem_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        core_req, core_we, core_stall, core_rvalid;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        dbg_req, dbg_gnt, dbg_valid;
  logic [31:0] dbg_addr, dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [16];
  int          total = 0;
  int          passed = 0;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(int k);
    return k == 0 ? 32'd0 : k == 1 ? 32'd4 : k == 2 ? 32'd122 : k == 3 ? 32'd8 : 32'(100 + k);
  endfunction

  function automatic logic [31:0] exp_word(int k);
    return k == 0 ? 32'd53 : init_word(k);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) mem[k] <= init_word(k);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[5:2]];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    dbg_req = 0; dbg_addr = 0;
    tick(); tick();
    core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'h77;
    dbg_req = 1; dbg_addr = 32'h4;
    #3;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_core_stall", core_stall, 0);
    chk("rst_core_rvalid", core_rvalid, 0);
    chk("rst_dbg_valid", dbg_valid, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; dbg_req = 0; dbg_addr = 0;
    tick();
    reset = 1'b0;
    // reset in the middle of an in-flight debug read
    dbg_req = 1; dbg_addr = 4;
    #3;
    chk("t1_gnt", dbg_gnt, 1);
    chk("t1_addr", mem_addr, 4);
    tick();
    dbg_req = 0;
    #2; reset = 1'b1; #1;
    chk("t1_async_valid", dbg_valid, 0);
    chk("t1_async_en", mem_en, 0);
    tick(); tick();
    #2; reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("t1_no_valid", dbg_valid, 0);
      chk("t1_rdata_zero", dbg_rdata, 0);
      tick();
    end
    // core store then load
    core_req = 1; core_we = 1; core_addr = 0; core_wdata = 53;
    #3;
    chk("t2_st_en", mem_en, 1);
    chk("t2_st_we", mem_we, 1);
    chk("t2_st_wdata", mem_wdata, 53);
    chk("t2_st_stall", core_stall, 0);
    tick();
    core_we = 0; core_wdata = 0;
    #3;
    chk("t2_ld_we", mem_we, 0);
    chk("t2_ld_en", mem_en, 1);
    chk("t2_ld_rvalid_early", core_rvalid, 0);
    chk("t2_ld_stall", core_stall, 0);
    tick();
    core_req = 0;
    #3;
    chk("t2_rvalid", core_rvalid, 1);
    chk("t2_rdata", core_rdata, 53);
    tick();
    #3;
    chk("t2_rvalid_drop", core_rvalid, 0);
    // debug read only
    dbg_req = 1; dbg_addr = 4;
    #3;
    chk("t3_gnt", dbg_gnt, 1);
    chk("t3_we", mem_we, 0);
    tick();
    dbg_req = 0;
    #3;
    chk("t3_gnt_drop", dbg_gnt, 0);
    chk("t3_valid_early", dbg_valid, 0);
    tick();
    #3;
    chk("t3_valid", dbg_valid, 1);
    chk("t3_rdata", dbg_rdata, 4);
    chk("t3_core_rvalid", core_rvalid, 0);
    tick();
    #3;
    chk("t3_valid_pulse", dbg_valid, 0);
    chk("t3_rdata_hold", dbg_rdata, 4);
    // starvation bound: C,C,C,C,D repeating
    core_req = 1; core_we = 0; core_addr = 0; dbg_req = 1; dbg_addr = 4;
    for (int i = 0; i < 20; i++) begin
      #3;
      chk("t4_gnt", dbg_gnt, (i % 5) == 4);
      chk("t4_stall", core_stall, (i % 5) == 4);
      chk("t4_addr", mem_addr, (i % 5) == 4 ? 4 : 0);
      tick();
    end
    core_req = 0; dbg_req = 0;
    tick(); tick(); tick();
    // mixed core and debug returns
    core_req = 1; core_we = 0; core_addr = 8;
    #3;
    chk("t5_core_addr", mem_addr, 8);
    tick();
    core_req = 0; dbg_req = 1; dbg_addr = 12;
    #3;
    chk("t5_core_rvalid", core_rvalid, 1);
    chk("t5_core_rdata", core_rdata, 122);
    chk("t5_dbg_gnt", dbg_gnt, 1);
    chk("t5_dbg_valid_early", dbg_valid, 0);
    tick();
    dbg_req = 0;
    #3;
    chk("t5_core_rvalid_drop", core_rvalid, 0);
    chk("t5_dbg_valid_mid", dbg_valid, 0);
    tick();
    #3;
    chk("t5_dbg_valid", dbg_valid, 1);
    chk("t5_dbg_rdata", dbg_rdata, 8);
    chk("t5_no_cross", core_rvalid, 0);
    tick();
    // continuous polling while the core is idle
    for (int i = 0; i < 12; i++) begin
      dbg_req = i < 10;
      dbg_addr = 32'(4 * i);
      #3;
      if (i < 10) chk("t6_gnt", dbg_gnt, 1);
      chk("t6_valid", dbg_valid, i >= 2);
      if (i >= 2) chk("t6_rdata", dbg_rdata, exp_word(i - 2));
      tick();
    end
    #3;
    chk("t6_valid_end", dbg_valid, 0);
    chk("t6_rdata_hold", dbg_rdata, exp_word(9));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
